// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and FSM state types for the memory-backed responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address and burst-legality check for one AXI3 burst.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  err
);

  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr + ADDR_WIDTH'(4);
    // {len,2'b11} equals (len+1)*4-1 for every legal wrap length
    wrap_mask = ADDR_WIDTH'({len, 2'b11});
    err = (size != SIZE_WORD) || (burst == 2'b11) ||
          ((burst == BURST_WRAP) && !wrap_len_ok(len));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end else begin
          next_addr = incr_addr;
        end
      end
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3 slave endpoint: independent write (AW/W/B) and read (AR/R) FSMs over a
// word-addressed byte-lane memory, one outstanding transaction per direction.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned SID_WIDTH  = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [SID_WIDTH-1:0]  AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [SID_WIDTH-1:0]  WID,
  input  logic [BUS_WIDTH-1:0]  WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [SID_WIDTH-1:0]  BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [SID_WIDTH-1:0]  ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [SID_WIDTH-1:0]  RID,
  output logic [BUS_WIDTH-1:0]  RDATA,
  output logic [3:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);

  logic unused_sig;
  assign unused_sig = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

  logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];

  // Write path
  w_state_e              w_state_q, w_state_d;
  logic [SID_WIDTH-1:0]  awid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, wnext;
  logic [3:0]            awlen_q, wcnt_q;
  logic [2:0]            awsize_q;
  logic [1:0]            awburst_q, bresp_q;
  logic                  werr_q, wburst_err;
  logic                  aw_hs, w_hs, wid_bad, w_last_beat, w_end, w_beat_err, mem_we;

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .addr      (waddr_q),
    .len       (awlen_q),
    .size      (awsize_q),
    .burst     (awburst_q),
    .next_addr (wnext),
    .err       (wburst_err)
  );

  always_comb begin
    aw_hs       = AWVALID && (w_state_q == W_IDLE);
    w_hs        = WVALID && (w_state_q == W_DATA);
    wid_bad     = (WID != awid_q);
    w_last_beat = (wcnt_q == awlen_q);
    w_end       = w_hs && (WLAST || w_last_beat);
    // WLAST must coincide exactly with beat LEN+1
    w_beat_err  = wid_bad || (WLAST != w_last_beat);
    mem_we      = w_hs && !wburst_err && !wid_bad;
  end

  always_comb begin
    w_state_d = w_state_q;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_d = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (w_end) w_state_d = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) w_state_q <= W_IDLE;
    else      w_state_q <= w_state_d;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        awid_q    <= AWID;
        waddr_q   <= AWADDR;
        awlen_q   <= AWLEN;
        awsize_q  <= AWSIZE;
        awburst_q <= AWBURST;
        wcnt_q    <= '0;
        werr_q    <= 1'b0;
      end
      if (w_hs) begin
        waddr_q <= wnext;
        wcnt_q  <= wcnt_q + 4'd1;
        werr_q  <= werr_q | w_beat_err;
        if (w_end) begin
          bresp_q <= (werr_q || w_beat_err || wburst_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  assign BID   = awid_q;
  assign BRESP = bresp_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem[waddr_q[IdxW+1:2]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // Read path
  r_state_e              r_state_q, r_state_d;
  logic [SID_WIDTH-1:0]  arid_q;
  logic [ADDR_WIDTH-1:0] raddr_q, rnext, rb_addr;
  logic [3:0]            arlen_q, rcnt_q, rb_len;
  logic [2:0]            arsize_q, rb_size;
  logic [1:0]            arburst_q, rb_burst, rresp_q;
  logic [BUS_WIDTH-1:0]  rdata_q, rfetch;
  logic                  rlast_q, rerr, ar_hs, r_hs, r_last_beat;
  logic [IdxW-1:0]       rfetch_idx;

  // In idle the shared checker sees the incoming AR so the first beat can be fetched at once
  always_comb begin
    if (r_state_q == R_IDLE) begin
      rb_addr  = ARADDR;
      rb_len   = ARLEN;
      rb_size  = ARSIZE;
      rb_burst = ARBURST;
    end else begin
      rb_addr  = raddr_q;
      rb_len   = arlen_q;
      rb_size  = arsize_q;
      rb_burst = arburst_q;
    end
  end

  axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .addr      (rb_addr),
    .len       (rb_len),
    .size      (rb_size),
    .burst     (rb_burst),
    .next_addr (rnext),
    .err       (rerr)
  );

  always_comb begin
    ar_hs       = ARVALID && (r_state_q == R_IDLE);
    r_hs        = RREADY && (r_state_q == R_DATA);
    r_last_beat = (rcnt_q == arlen_q);
    rfetch_idx  = (r_state_q == R_IDLE) ? ARADDR[IdxW+1:2] : rnext[IdxW+1:2];
    rfetch      = rerr ? '0 : mem[rfetch_idx];
  end

  always_comb begin
    r_state_d = r_state_q;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_d = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && r_last_beat) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state_q <= R_IDLE;
    else      r_state_q <= r_state_d;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      arid_q    <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else if (ar_hs) begin
      arid_q    <= ARID;
      raddr_q   <= ARADDR;
      arlen_q   <= ARLEN;
      arsize_q  <= ARSIZE;
      arburst_q <= ARBURST;
      rcnt_q    <= '0;
      rdata_q   <= rfetch;
      rresp_q   <= rerr ? RESP_SLVERR : RESP_OKAY;
      rlast_q   <= (ARLEN == 4'd0);
    end else if (r_hs) begin
      if (r_last_beat) begin
        rlast_q <= 1'b0;
      end else begin
        raddr_q <= rnext;
        rcnt_q  <= rcnt_q + 4'd1;
        rdata_q <= rfetch;
        rlast_q <= ((rcnt_q + 4'd1) == arlen_q);
      end
    end
  end

  assign RID   = arid_q;
  assign RDATA = rdata_q;
  assign RRESP = {2'b00, rresp_q};
  assign RLAST = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: reset values, directed bursts, a vector
// table of response cases, and randomized bursts against a word-array model.
module tb_axi_mem_slave;

  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic [SW-1:0] AWID, WID, BID, ARID, RID;
  logic [31:0]   AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]    AWLEN, ARLEN, WSTRB, RRESP;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST, BRESP;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_mem_slave #(.SID_WIDTH(SW), .ADDR_WIDTH(32), .BUS_WIDTH(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .clr(clr),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(2'b00), .AWCACHE(4'h0), .AWPROT(3'b000), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(2'b00), .ARCACHE(4'h0), .ARPROT(3'b000), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mm [256];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] got [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic expired(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", nm);
  endtask

  function automatic bit wrap_ok(input int len);
    return len == 1 || len == 3 || len == 7 || len == 15;
  endfunction

  function automatic bit m_err(input int len, input logic [2:0] size, input logic [1:0] burst);
    return size != 3'd2 || burst == 2'd3 || (burst == 2'd2 && !wrap_ok(len));
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input int len,
                                         input logic [1:0] burst);
    int unsigned bytes;
    logic [31:0] base;
    if (burst == 2'd0) return a;
    if (burst == 2'd2 && wrap_ok(len)) begin
      bytes = (len + 1) * 4;
      base  = a - (a % bytes);
      return base + ((a - base + 4) % bytes);
    end
    return a + 32'd4;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % 256);
  endfunction

  task automatic wr(input logic [SW-1:0] id, input logic [31:0] addr, input int len,
                    input logic [2:0] size, input logic [1:0] burst, input int wlast_beat,
                    input int bad_beat, input int bdelay,
                    output logic [1:0] resp, output logic [1:0] exp_resp);
    logic [31:0] a;
    bit berr, xerr, hs;
    int nb, guard;
    resp = 2'bxx;
    berr = m_err(len, size, burst);
    xerr = berr || (wlast_beat != len);
    AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    hs = 0; guard = 0;
    while (!hs && guard < 50) begin
      hs = AWREADY; @(posedge clk); #1; guard++;
    end
    AWVALID = 1'b0;
    nb = ((wlast_beat < len) ? wlast_beat : len) + 1;
    if (bad_beat >= 0 && bad_beat < nb) xerr = 1;
    exp_resp = xerr ? 2'b10 : 2'b00;
    if (!hs) begin expired("aw_handshake"); return; end
    a = addr;
    for (int k = 0; k < nb; k++) begin
      WID = (k == bad_beat) ? (id ^ SW'(1)) : id;
      WDATA = wd[k]; WSTRB = ws[k]; WLAST = (k == wlast_beat); WVALID = 1'b1;
      hs = 0; guard = 0;
      while (!hs && guard < 50) begin
        hs = WREADY; @(posedge clk); #1; guard++;
      end
      if (!hs) begin WVALID = 1'b0; WLAST = 1'b0; expired("w_handshake"); return; end
      if (!berr && k != bad_beat) begin
        for (int b = 0; b < 4; b++) if (ws[k][b]) mm[m_idx(a)][8*b +: 8] = wd[k][8*b +: 8];
      end
      a = m_next(a, len, burst);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("bvalid_latency", 32'(BVALID), 1);
    guard = 0;
    while (!BVALID && guard < 50) begin @(posedge clk); #1; guard++; end
    if (!BVALID) begin expired("b_wait"); return; end
    chk("bid", 32'(BID), 32'(id));
    resp = BRESP;
    for (int d = 0; d < bdelay; d++) begin
      @(posedge clk); #1;
      chk("bvalid_held", 32'(BVALID), 1);
      chk("bresp_held", 32'(BRESP), 32'(resp));
    end
    BREADY = 1'b1; @(posedge clk); #1; BREADY = 1'b0;
    chk("bvalid_drop", 32'(BVALID), 0);
    chk("awready_back", 32'(AWREADY), 1);
  endtask

  // mode: 0 always ready, 1 toggling, 2 random
  task automatic rd(input logic [SW-1:0] id, input logic [31:0] addr, input int len,
                    input logic [2:0] size, input logic [1:0] burst, input int mode);
    logic [31:0] ex [16];
    logic [31:0] a, pd;
    bit err, hs, stalled;
    int i, guard;
    err = m_err(len, size, burst);
    a = addr;
    for (int k = 0; k <= len; k++) begin
      ex[k] = err ? 32'd0 : mm[m_idx(a)];
      a = m_next(a, len, burst);
    end
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    hs = 0; guard = 0;
    while (!hs && guard < 50) begin
      hs = ARREADY; @(posedge clk); #1; guard++;
    end
    ARVALID = 1'b0;
    if (!hs) begin expired("ar_handshake"); return; end
    chk("rvalid_latency", 32'(RVALID), 1);
    i = 0; guard = 0; stalled = 0; pd = '0;
    while (i <= len && guard < 300) begin
      case (mode)
        0:       RREADY = 1'b1;
        1:       RREADY = guard[0];
        default: RREADY = 1'($urandom_range(0, 1));
      endcase
      if (RVALID) begin
        if (stalled) chk("rdata_stable", RDATA, pd);
        chk("rdata", RDATA, ex[i]);
        chk("rid", 32'(RID), 32'(id));
        chk("rresp", 32'(RRESP), err ? 32'd2 : 32'd0);
        chk("rlast", 32'(RLAST), 32'(i == len));
        got[i] = RDATA;
        stalled = !RREADY;
        pd = RDATA;
        if (RREADY) i++;
      end
      @(posedge clk); #1; guard++;
    end
    RREADY = 1'b0;
    if (i <= len) begin expired("r_beats"); return; end
    chk("rvalid_end", 32'(RVALID), 0);
    chk("arready_back", 32'(ARREADY), 1);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast;
    int          badb;
    logic [1:0]  exp_resp;
  } wvec_t;

  wvec_t tv [9];

  initial begin
    logic [1:0]  resp, xr;
    logic [31:0] ra, rb, ex [8];
    int          len, r;
    logic [1:0]  burst;
    logic [2:0]  size;

    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 0; RREADY = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(AWREADY), 1);
    chk("rst_arready", 32'(ARREADY), 1);
    chk("rst_wready", 32'(WREADY), 0);
    chk("rst_bvalid", 32'(BVALID), 0);
    chk("rst_rvalid", 32'(RVALID), 0);
    chk("rst_rlast", 32'(RLAST), 0);
    chk("rst_ids", 32'({BID, RID}), 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_resps", 32'({BRESP, RRESP}), 0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Give every word a known value so the model is complete
    for (int blk = 0; blk < 16; blk++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      wr(6'(blk), 32'(blk * 64), 15, 3'd2, 2'd1, 15, -1, 0, resp, xr);
      chk("fill_bresp", 32'(resp), 0);
    end

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(6'd5, 32'h10, 0, 3'd2, 2'd1, 0, -1, 0, resp, xr);
    chk("single_bresp", 32'(resp), 0);
    rd(6'd5, 32'h10, 0, 3'd2, 2'd1, 0);
    chk("single_rdata", got[0], 32'hDEADBEEF);

    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    wr(6'd9, 32'h20, 3, 3'd2, 2'd1, 3, -1, 0, resp, xr);
    chk("incr4_bresp", 32'(resp), 0);
    rd(6'd9, 32'h20, 3, 3'd2, 2'd1, 1);
    for (int k = 0; k < 4; k++) chk("incr4_rdata", got[k], 32'(k + 1));

    for (int k = 0; k < 4; k++) begin wd[k] = 32'h30 + 32'(4 * k); ws[k] = 4'hF; end
    wr(6'd1, 32'h30, 3, 3'd2, 2'd1, 3, -1, 0, resp, xr);
    rd(6'd2, 32'h38, 3, 3'd2, 2'd2, 0);
    chk("wrap_b0", got[0], 32'h38);
    chk("wrap_b1", got[1], 32'h3C);
    chk("wrap_b2", got[2], 32'h30);
    chk("wrap_b3", got[3], 32'h34);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    wr(6'd3, 32'h50, 0, 3'd2, 2'd1, 0, -1, 0, resp, xr);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    wr(6'd3, 32'h50, 0, 3'd2, 2'd1, 0, -1, 0, resp, xr);
    rd(6'd3, 32'h50, 0, 3'd2, 2'd1, 0);
    chk("strb_merge", got[0], 32'h11BB33DD);

    tv[0] = '{32'h40, 3, 3'd2, 2'd1, 3, -1, 2'b00};
    tv[1] = '{32'h80, 0, 3'd1, 2'd1, 0, -1, 2'b10};
    tv[2] = '{32'h84, 0, 3'd2, 2'd1, 0, 0, 2'b10};
    tv[3] = '{32'h90, 3, 3'd2, 2'd1, 1, -1, 2'b10};
    tv[4] = '{32'hA0, 1, 3'd2, 2'd1, 5, -1, 2'b10};
    tv[5] = '{32'hB0, 2, 3'd2, 2'd2, 2, -1, 2'b10};
    tv[6] = '{32'hC0, 1, 3'd2, 2'd3, 1, -1, 2'b10};
    tv[7] = '{32'hC8, 3, 3'd2, 2'd2, 3, -1, 2'b00};
    tv[8] = '{32'hD0, 2, 3'd2, 2'd0, 2, -1, 2'b00};
    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      wr(6'(v + 16), tv[v].addr, tv[v].len, tv[v].size, tv[v].burst, tv[v].wlast,
         tv[v].badb, v % 3, resp, xr);
      chk($sformatf("vec%0d_bresp", v), 32'(resp), 32'(tv[v].exp_resp));
      rd(6'(v + 32), tv[v].addr, tv[v].len, tv[v].size, tv[v].burst, 2);
    end

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      len = $urandom_range(0, 15);
      burst = 2'd1;
      if (r >= 6 && r <= 7) burst = 2'd0;
      if (r >= 8) begin
        burst = 2'd2;
        len = (2 << $urandom_range(0, 3)) - 1;
      end
      size = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      ra = $urandom & 32'hFFFF_FFFC;
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
      wr(6'($urandom), ra, len, size, burst, len, -1, $urandom_range(0, 3), resp, xr);
      chk("rand_bresp", 32'(resp), 32'(xr));
      rd(6'($urandom), ra, len, 3'd2, burst, 2);
      rb = $urandom & 32'hFFFF_FFFC;
      rd(6'($urandom), rb, $urandom_range(0, 15), 3'd2, 2'd1, 2);
    end

    // Read stalled while a write completes with a slow B, then reset mid-read
    for (int k = 0; k < 8; k++) ex[k] = mm[m_idx(32'h180 + 32'(4 * k))];
    ARID = 6'd7; ARADDR = 32'h180; ARLEN = 4'd7; ARSIZE = 3'd2; ARBURST = 2'd1;
    ARVALID = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    chk("conc_rvalid", 32'(RVALID), 1);
    for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    wr(6'd11, 32'h100, 7, 3'd2, 2'd1, 7, -1, 5, resp, xr);
    chk("conc_bresp", 32'(resp), 0);
    chk("conc_rstall", RDATA, ex[0]);
    RREADY = 1'b1;
    @(posedge clk); #1;
    chk("conc_beat1", RDATA, ex[1]);
    @(posedge clk); #1;
    RREADY = 1'b0;
    chk("conc_beat2", RDATA, ex[2]);
    chk("conc_rvalid_mid", 32'(RVALID), 1);
    clr = 1'b0;
    #1;
    chk("clr_rvalid", 32'(RVALID), 0);
    chk("clr_arready", 32'(ARREADY), 1);
    chk("clr_rlast", 32'(RLAST), 0);
    chk("clr_bvalid", 32'(BVALID), 0);
    @(posedge clk); #1;
    clr = 1'b1;
    RREADY = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_clr_rvalid", 32'(RVALID), 0);
    end
    RREADY = 1'b0;
    rd(6'd12, 32'h100, 7, 3'd2, 2'd1, 2);
    rd(6'd13, 32'h180, 7, 3'd2, 2'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
